// File: rtl/dmem_if.sv
// CPU and preload bus for the data memory responder.
// The test side drives through master; the memory side uses slave.
interface dmem_if;
  logic [9:0]  RAddr_d;
  logic [1:0]  RSize;
  logic [31:0] Rdata_d;
  logic        Wen;
  logic [1:0]  WSize;
  logic [9:0]  WAddr_d;
  logic [31:0] Wdata_d;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;

  modport master (
    output RAddr_d, RSize, Wen, WSize, WAddr_d, Wdata_d,
           ld_valid, ld_addr, ld_data, ld_done,
    input  Rdata_d, ld_ready
  );
  modport slave (
    input  RAddr_d, RSize, Wen, WSize, WAddr_d, Wdata_d,
           ld_valid, ld_addr, ld_data, ld_done,
    output Rdata_d, ld_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// 1 KiB big-endian byte memory: word preload in LOAD, then CPU reads/writes in RUN.
// Reads have one cycle of latency and see same-edge writes (write-first).
module dmem_responder #(
  parameter int NUM_LANES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_if.slave       bus,
  output logic        run,
  output logic        err_misalign,
  output logic [15:0] wr_count
);
  typedef enum logic {LOAD, RUN} state_e;
  state_e state_q, state_d;

  logic [7:0] mem [0:1023];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && bus.ld_done) state_d = RUN;
  end

  assign run          = (state_q == RUN);
  assign bus.ld_ready = (state_q == LOAD);

  logic r_mis, w_req, w_mis, cpu_we;
  assign r_mis  = (bus.RSize == 2'b11 && |bus.RAddr_d[1:0]) ||
                  (bus.RSize == 2'b10 && bus.RAddr_d[0]);
  assign w_req  = bus.Wen && |bus.WSize;
  assign w_mis  = w_req && ((bus.WSize == 2'b11 && |bus.WAddr_d[1:0]) ||
                            (bus.WSize == 2'b10 && bus.WAddr_d[0]));
  assign cpu_we = run && w_req && !w_mis;

  // Single write port shared by preload and CPU; data is left-justified so
  // offset k from wa always takes byte lane k counting from the MSB.
  logic [9:0]           wa;
  logic [31:0]          wl;
  logic [NUM_LANES-1:0] wmask;

  always_comb begin
    wa    = {bus.ld_addr, 2'b00};
    wl    = bus.ld_data;
    wmask = {NUM_LANES{bus.ld_valid && bus.ld_ready}};
    if (run) begin
      wa    = bus.WAddr_d;
      wl    = bus.Wdata_d;
      wmask = '0;
      case (bus.WSize)
        2'b11:   begin wl = bus.Wdata_d;                   wmask = 4'b1111; end
        2'b10:   begin wl = {bus.Wdata_d[15:0], 16'h0000}; wmask = 4'b0011; end
        2'b01:   begin wl = {bus.Wdata_d[7:0], 24'h000000}; wmask = 4'b0001; end
        default: begin wl = bus.Wdata_d;                   wmask = 4'b0000; end
      endcase
      if (!cpu_we) wmask = '0;
    end
  end

  // No reset on the array: contents survive reset, but a write is dropped
  // on any edge where reset is held.
  always_ff @(posedge clk)
    if (rst_n)
      for (int k = 0; k < NUM_LANES; k++)
        if (wmask[k]) mem[wa + 10'(k)] <= wl[31-8*k -: 8];

  logic [NUM_LANES-1:0][7:0] rbyte;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [9:0] a, off;
    logic [7:0] wb;
    assign a   = bus.RAddr_d + 10'(i);
    assign off = a - wa;
    always_comb begin
      case (off[1:0])
        2'd0:    wb = wl[31:24];
        2'd1:    wb = wl[23:16];
        2'd2:    wb = wl[15:8];
        default: wb = wl[7:0];
      endcase
    end
    assign rbyte[i] = (off < 10'd4 && wmask[off[1:0]]) ? wb : mem[a];
  end

  logic [31:0] rd_val;
  always_comb begin
    case (bus.RSize)
      2'b11:   rd_val = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
      2'b10:   rd_val = {16'h0000, rbyte[0], rbyte[1]};
      2'b01:   rd_val = {24'h000000, rbyte[0]};
      default: rd_val = 32'h0;
    endcase
    if (r_mis) rd_val = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.Rdata_d  <= 32'h0;
      err_misalign <= 1'b0;
      wr_count     <= 16'h0;
    end else begin
      bus.Rdata_d  <= run ? rd_val : 32'h0;
      err_misalign <= err_misalign | (run && (r_mis || w_mis));
      if (cpu_we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: expected read data is queued when a request is driven
// and popped when the registered response appears one edge later.
module tb_dmem_responder;
  logic        clk, rst_n;
  logic        run, err_misalign;
  logic [15:0] wr_count;

  dmem_if bus();

  dmem_responder dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .run(run), .err_misalign(err_misalign), .wr_count(wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  logic [7:0]  mm [1024];
  logic [31:0] exp_q [$];
  logic [15:0] exp_cnt;
  logic        exp_err;

  function automatic bit mis(input logic [1:0] s, input logic [9:0] a);
    return (s == 2'b11 && a[1:0] != 2'b00) || (s == 2'b10 && a[0]);
  endfunction

  function automatic logic [31:0] mr(input logic [1:0] s, input logic [9:0] a);
    if (mis(s, a)) return 32'h0;
    case (s)
      2'b11:   return {mm[a], mm[a+1], mm[a+2], mm[a+3]};
      2'b10:   return {16'h0, mm[a], mm[a+1]};
      2'b01:   return {24'h0, mm[a]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic idle();
    bus.Wen = 0; bus.WSize = 0; bus.WAddr_d = 0; bus.Wdata_d = 0;
    bus.RSize = 0; bus.RAddr_d = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.ld_done = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One RUN-state cycle: optional write and read on the same edge.
  task automatic op(input logic we, input logic [1:0] ws, input logic [9:0] wa,
                    input logic [31:0] wd, input logic [1:0] rs,
                    input logic [9:0] ra, input string nm);
    logic [31:0] got, e;
    bus.Wen = we; bus.WSize = ws; bus.WAddr_d = wa; bus.Wdata_d = wd;
    bus.RSize = rs; bus.RAddr_d = ra;
    if (we && ws != 2'b00) begin
      if (mis(ws, wa)) exp_err = 1'b1;
      else begin
        case (ws)
          2'b11: begin mm[wa] = wd[31:24]; mm[wa+1] = wd[23:16];
                       mm[wa+2] = wd[15:8]; mm[wa+3] = wd[7:0]; end
          2'b10: begin mm[wa] = wd[15:8]; mm[wa+1] = wd[7:0]; end
          default: mm[wa] = wd[7:0];
        endcase
        if (exp_cnt != 16'hFFFF) exp_cnt++;
      end
    end
    if (mis(rs, ra)) exp_err = 1'b1;
    exp_q.push_back(mr(rs, ra));
    tick();
    idle();
    got = bus.Rdata_d;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++; $display("FAIL %s rdata got=%h exp=%h", nm, got, e);
    end
    checks++;
    if (wr_count !== exp_cnt) begin
      failures++; $display("FAIL %s wr_count got=%0d exp=%0d", nm, wr_count, exp_cnt);
    end
    checks++;
    if (err_misalign !== exp_err) begin
      failures++; $display("FAIL %s err got=%b exp=%b", nm, err_misalign, exp_err);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    exp_cnt = 0; exp_err = 0;
    #3;
    checks++;
    if (run !== 1'b0 || bus.ld_ready !== 1'b1 || bus.Rdata_d !== 32'h0 ||
        err_misalign !== 1'b0 || wr_count !== 16'h0) begin
      failures++;
      $display("FAIL reset run=%b rdy=%b rd=%h err=%b cnt=%0d exp 0/1/0/0/0",
               run, bus.ld_ready, bus.Rdata_d, err_misalign, wr_count);
    end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // Preload 8 words; CPU traffic during LOAD must be ignored; last word
  // carries ld_done in the same cycle.
  task automatic test_preload();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h11223344 : $urandom;
      bus.ld_valid = 1; bus.ld_addr = 8'(i); bus.ld_data = w; bus.ld_done = (i == 7);
      bus.Wen = 1; bus.WSize = 2'b11; bus.WAddr_d = 10'(4*i); bus.Wdata_d = 32'hBAD0BAD0;
      bus.RSize = 2'b11; bus.RAddr_d = 0;
      {mm[4*i], mm[4*i+1], mm[4*i+2], mm[4*i+3]} = w;
      tick();
      idle();
      checks++;
      if (bus.Rdata_d !== 32'h0 || run !== (i == 7) || bus.ld_ready !== (i != 7)) begin
        failures++;
        $display("FAIL preload%0d rd=%h run=%b rdy=%b exp 0/%b/%b",
                 i, bus.Rdata_d, run, bus.ld_ready, i == 7, i != 7);
      end
    end
    // Loader ignored in RUN
    bus.ld_valid = 1; bus.ld_addr = 0; bus.ld_data = 32'hFFFFFFFF; bus.ld_done = 1;
    tick();
    idle();
    checks++;
    if (wr_count !== 16'h0) begin
      failures++; $display("FAIL load_cpu_ignored wr_count got=%0d exp=0", wr_count);
    end
  endtask

  task automatic test_reads();
    op(0, 0, 0, 0, 2'b11, 10'd0, "word_rd0");
    checks++;
    if (bus.Rdata_d !== 32'h11223344) begin
      failures++; $display("FAIL word_rd0_const got=%h exp=11223344", bus.Rdata_d);
    end
    op(0, 0, 0, 0, 2'b01, 10'd2, "byte_rd2");
    checks++;
    if (bus.Rdata_d !== 32'h00000033) begin
      failures++; $display("FAIL byte_rd2_const got=%h exp=00000033", bus.Rdata_d);
    end
    op(0, 0, 0, 0, 2'b10, 10'd2, "half_rd2");
    checks++;
    if (bus.Rdata_d !== 32'h00003344) begin
      failures++; $display("FAIL half_rd2_const got=%h exp=00003344", bus.Rdata_d);
    end
    op(0, 0, 0, 0, 2'b00, 10'd0, "no_read");
    op(0, 0, 0, 0, 2'b11, 10'd28, "word_rd28");
  endtask

  task automatic test_writes();
    op(1, 2'b01, 10'd1, 32'h000000AA, 2'b00, 0, "byte_wr1");
    op(0, 0, 0, 0, 2'b11, 10'd0, "rd_after_byte");
    checks++;
    if (bus.Rdata_d !== 32'h11AA3344 || wr_count !== 16'd1) begin
      failures++;
      $display("FAIL byte_wr_const rd=%h cnt=%0d exp 11AA3344/1", bus.Rdata_d, wr_count);
    end
    op(1, 2'b10, 10'd10, 32'h0000C0DE, 2'b11, 10'd8, "half_wr10");
    op(1, 2'b00, 10'd12, 32'h12345678, 2'b11, 10'd12, "wsize0_noop");
    op(1, 2'b11, 10'd1020, 32'hCAFEF00D, 2'b00, 0, "word_wr1020");
    op(0, 0, 0, 0, 2'b11, 10'd1020, "word_rd1020");
  endtask

  task automatic test_misalign();
    op(1, 2'b11, 10'd2, 32'hFFFFFFFF, 2'b00, 0, "mis_word_wr");
    op(0, 0, 0, 0, 2'b11, 10'd0, "rd_after_mis");
    op(0, 0, 0, 0, 2'b10, 10'd3, "mis_half_rd");
    op(1, 2'b10, 10'd5, 32'h0000FFFF, 2'b11, 10'd6, "mis_half_wr_mis_rd");
    op(0, 0, 0, 0, 2'b11, 10'd4, "rd_after_mis_half");
  endtask

  task automatic test_same_edge();
    op(1, 2'b11, 10'd4, 32'hDEADBEEF, 2'b11, 10'd4, "same_edge_word");
    checks++;
    if (bus.Rdata_d !== 32'hDEADBEEF) begin
      failures++; $display("FAIL same_edge_const got=%h exp=DEADBEEF", bus.Rdata_d);
    end
    op(1, 2'b01, 10'd9, 32'h00000055, 2'b11, 10'd8, "partial_byte");
    op(1, 2'b10, 10'd18, 32'h0000A5A5, 2'b11, 10'd16, "partial_half");
    op(1, 2'b11, 10'd20, 32'h01020304, 2'b10, 10'd22, "half_in_word");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] ws, rs;
      logic [9:0] wa, ra;
      ws = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      wa = 10'($urandom_range(0, 31));
      ra = 10'($urandom_range(0, 31));
      if (ws == 2'b11) wa[1:0] = 0; else if (ws == 2'b10) wa[0] = 0;
      if (rs == 2'b11) ra[1:0] = 0; else if (rs == 2'b10) ra[0] = 0;
      op(1'($urandom_range(0, 1)), ws, wa, $urandom, rs, ra, "b2b");
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] keep;
    keep = {mm[0], mm[1], mm[2], mm[3]};
    bus.Wen = 1; bus.WSize = 2'b11; bus.WAddr_d = 0; bus.Wdata_d = 32'hFFFFFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (run !== 1'b0 || bus.ld_ready !== 1'b1 || wr_count !== 16'h0 ||
        err_misalign !== 1'b0 || bus.Rdata_d !== 32'h0) begin
      failures++;
      $display("FAIL midrun_reset run=%b rdy=%b cnt=%0d err=%b rd=%h exp 0/1/0/0/0",
               run, bus.ld_ready, wr_count, err_misalign, bus.Rdata_d);
    end
    tick();
    rst_n = 1'b1;
    exp_cnt = 0; exp_err = 0;
    tick(); tick();
    idle();
    bus.ld_done = 1;
    tick();
    idle();
    checks++;
    if (run !== 1'b1 || wr_count !== 16'h0) begin
      failures++; $display("FAIL reload run=%b cnt=%0d exp 1/0", run, wr_count);
    end
    op(0, 0, 0, 0, 2'b11, 10'd0, "mem_kept");
    checks++;
    if (bus.Rdata_d !== keep) begin
      failures++; $display("FAIL mem_kept_const got=%h exp=%h", bus.Rdata_d, keep);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_preload();
    test_reads();
    test_writes();
    test_misalign();
    test_same_edge();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
